// File: rtl/pred_ctrl_pkg.sv
// Shared types and constants for the predicate-control sequencer.
// Context word layout, IDLE word, legal select encodings, FSM states.
package pred_ctrl_pkg;

  localparam int IN_W    = 9;
  localparam int OUT_W   = 9;
  localparam int PUT_W   = 6;
  localparam int PRED_W  = 6;
  localparam int SEND_W  = 6;
  localparam int PE2FU_W = 4;
  localparam int WORD_W  = 47;

  // Packed MSB->LSB: in, out, put_in, put_out, pred, send, pe2fu, wb
  localparam int WB_LSB      = 0;
  localparam int PE2FU_LSB   = 1;
  localparam int SEND_LSB    = 5;
  localparam int PRED_LSB    = 11;
  localparam int PUT_OUT_LSB = 17;
  localparam int PUT_IN_LSB  = 23;
  localparam int OUT_LSB     = 29;
  localparam int IN_LSB      = 38;

  localparam int SCRATCH_DEF = 63;

  typedef logic [WORD_W-1:0] ctx_word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam logic [IN_W-1:0] IN_SEL_NONE = 9'h000;
  localparam logic [IN_W-1:0] IN_SEL_A    = 9'h008;
  localparam logic [IN_W-1:0] IN_SEL_B    = 9'h001;
  localparam logic [IN_W-1:0] IN_SEL_C    = 9'h002;
  localparam logic [IN_W-1:0] IN_SEL_D    = 9'h010;

  localparam logic [PE2FU_W-1:0] FU_SEL_NONE = 4'h0;
  localparam logic [PE2FU_W-1:0] FU_SEL_A    = 4'h1;
  localparam logic [PE2FU_W-1:0] FU_SEL_B    = 4'h2;
  localparam logic [PE2FU_W-1:0] FU_SEL_C    = 4'h4;
  localparam logic [PE2FU_W-1:0] FU_SEL_D    = 4'h8;

  function automatic ctx_word_t idle_word(
    input logic [PUT_W-1:0] scratch
  );
    ctx_word_t w;
    w = '0;
    w[PUT_IN_LSB +: PUT_W]  = scratch;
    w[PUT_OUT_LSB +: PUT_W] = scratch;
    return w;
  endfunction

  localparam ctx_word_t IDLE_WORD =
    idle_word(PUT_W'(SCRATCH_DEF));

  function automatic logic word_legal(
    input ctx_word_t w
  );
    logic [IN_W-1:0]    s_in;
    logic [PE2FU_W-1:0] s_fu;
    logic               ok_in;
    logic               ok_fu;
    s_in  = w[IN_LSB +: IN_W];
    s_fu  = w[PE2FU_LSB +: PE2FU_W];
    ok_in = s_in inside {IN_SEL_NONE, IN_SEL_A,
                         IN_SEL_B, IN_SEL_C, IN_SEL_D};
    ok_fu = s_fu inside {FU_SEL_NONE, FU_SEL_A,
                         FU_SEL_B, FU_SEL_C, FU_SEL_D};
    return ok_in && ok_fu;
  endfunction

endpackage

// File: rtl/pred_ctrl_seq_mem.sv
// Context memory: DEPTH x WORD_W array, synchronous write,
// registered read that doubles as the issued-word register.
module pred_ctrl_seq_mem
  import pred_ctrl_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  ctx_word_t       wdata_i,
  input  logic            re_i,
  input  logic [AW-1:0]   raddr_i,
  output ctx_word_t       rdata_o
);

  ctx_word_t mem_q [DEPTH];
  ctx_word_t rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pred_ctrl_seq.sv
// Context sequencer driving one PE predicate register file.
// Optional config legality check: PRED_CTRL_ERR_CHK_EN.
module pred_ctrl_seq
  import pred_ctrl_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int ITER_W      = 8,
  parameter int SCRATCH_IDX = 63
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                cfg_we,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [WORD_W-1:0]   cfg_data,
  input  logic                start,
  input  logic [AW-1:0]       ctx_last,
  input  logic [ITER_W-1:0]   iter_num,
  input  logic                stall,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [IN_W-1:0]     control_in_p,
  output logic [PUT_W-1:0]    control_put_in_p,
  output logic [PUT_W-1:0]    control_put_out_p,
  output logic                write_back_p,
  output logic [PRED_W-1:0]   control_pred,
  output logic [SEND_W-1:0]   control_send_p,
  output logic [OUT_W-1:0]    control_out_p,
  output logic [PE2FU_W-1:0]  control_pe2fu_p
);

  localparam ctx_word_t IDLE_W =
    (SCRATCH_IDX == SCRATCH_DEF) ? IDLE_WORD
      : idle_word(PUT_W'(SCRATCH_IDX));

  state_e            state_q, state_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [AW-1:0]     last_q, last_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [ITER_W-1:0] num_q, num_d;
  logic              fin_q, fin_d;
  logic              vld_q, vld_d;

  logic              issue;
  logic [AW-1:0]     cur_pc;
  logic [AW-1:0]     cur_last;
  logic [ITER_W-1:0] cur_it;
  logic [ITER_W-1:0] cur_num;
  logic              cfg_acc;
  ctx_word_t         rdata;
  ctx_word_t         out_w;

  // Config writes only land in IDLE and lose to a same-cycle start.
  assign cfg_acc = cfg_we && (state_q == ST_IDLE) && !start;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    iter_d   = iter_q;
    last_d   = last_q;
    num_d    = num_q;
    fin_d    = fin_q;
    vld_d    = 1'b0;
    issue    = 1'b0;
    cur_pc   = pc_q;
    cur_it   = iter_q;
    cur_last = last_q;
    cur_num  = num_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          last_d = ctx_last;
          num_d  = iter_num;
          pc_d   = '0;
          iter_d = '0;
          fin_d  = 1'b0;
          if (iter_num != '0) begin
            state_d  = ST_RUN;
            issue    = 1'b1;
            cur_pc   = '0;
            cur_it   = '0;
            cur_last = ctx_last;
            cur_num  = iter_num;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (fin_q) begin
          state_d = ST_DONE;
        end else if (!stall) begin
          issue = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // fin marks that the word now being issued is the last one.
    if (issue) begin
      vld_d = 1'b1;
      fin_d = (cur_pc == cur_last) &&
              (cur_it == cur_num - ITER_W'(1));
      if (cur_pc == cur_last) begin
        pc_d   = '0;
        iter_d = cur_it + ITER_W'(1);
      end else begin
        pc_d   = cur_pc + AW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      iter_q  <= '0;
      last_q  <= '0;
      num_q   <= '0;
      fin_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      iter_q  <= iter_d;
      last_q  <= last_d;
      num_q   <= num_d;
      fin_q   <= fin_d;
      vld_q   <= vld_d;
    end
  end

  pred_ctrl_seq_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (CLK),
    .we_i    (cfg_acc),
    .waddr_i (cfg_addr),
    .wdata_i (cfg_data),
    .re_i    (issue),
    .raddr_i (cur_pc),
    .rdata_o (rdata)
  );

`ifdef PRED_CTRL_ERR_CHK_EN
  logic err_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_q <= 1'b0;
    end else if (cfg_acc && !word_legal(cfg_data)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign out_w = vld_q ? rdata : IDLE_W;

  assign control_in_p      = out_w[IN_LSB +: IN_W];
  assign control_out_p     = out_w[OUT_LSB +: OUT_W];
  assign control_put_in_p  = out_w[PUT_IN_LSB +: PUT_W];
  assign control_put_out_p = out_w[PUT_OUT_LSB +: PUT_W];
  assign control_pred      = out_w[PRED_LSB +: PRED_W];
  assign control_send_p    = out_w[SEND_LSB +: SEND_W];
  assign control_pe2fu_p   = out_w[PE2FU_LSB +: PE2FU_W];
  assign write_back_p      = out_w[WB_LSB];

endmodule

// File: tb/tb_pred_ctrl_seq.sv
// Directed scoreboard bench for pred_ctrl_seq.
// Expected cycles are queued at start, popped each cycle.
module tb_pred_ctrl_seq;

  localparam int AW = 4;
  localparam int IW = 8;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [46:0] cfg_data = '0;
  logic        start = 1'b0;
  logic [3:0]  ctx_last = '0;
  logic [7:0]  iter_num = '0;
  logic        stall = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, err;
  logic [8:0]  c_in, c_out;
  logic [5:0]  c_pin, c_pout, c_pred, c_send;
  logic [3:0]  c_fu;
  logic        c_wb;
  logic [46:0] obs_w;

  pred_ctrl_seq dut (
    .CLK               (CLK),
    .RST_N             (RST_N),
    .cfg_we            (cfg_we),
    .cfg_addr          (cfg_addr),
    .cfg_data          (cfg_data),
    .start             (start),
    .ctx_last          (ctx_last),
    .iter_num          (iter_num),
    .stall             (stall),
    .abort             (abort),
    .busy              (busy),
    .done              (done),
    .err               (err),
    .control_in_p      (c_in),
    .control_put_in_p  (c_pin),
    .control_put_out_p (c_pout),
    .write_back_p      (c_wb),
    .control_pred      (c_pred),
    .control_send_p    (c_send),
    .control_out_p     (c_out),
    .control_pe2fu_p   (c_fu)
  );

  always #5 CLK = ~CLK;

  assign obs_w = {c_in, c_out, c_pin, c_pout,
                  c_pred, c_send, c_fu, c_wb};

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [46:0] w;
  } exp_t;

  exp_t        q[$];
  logic [46:0] ctx_m [16];
  int          checks = 0;
  int          failures = 0;
  int          tnum = 0;
  logic        err_exp;

  function automatic logic [46:0] pk(
    input logic [8:0] in_p, input logic [8:0] out_p,
    input logic [5:0] pin, input logic [5:0] pout,
    input logic [5:0] pred, input logic [5:0] send,
    input logic [3:0] fu, input logic wb
  );
    return {in_p, out_p, pin, pout, pred, send, fu, wb};
  endfunction

  logic [46:0] IDLE_W;
  logic [46:0] JUNK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic push(input logic b, input logic d,
                      input logic [46:0] w);
    exp_t e;
    e.busy = b;
    e.done = d;
    e.w    = w;
    q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    e = q.pop_front();
    chk({tag, "_word"}, 64'(obs_w), 64'(e.w));
    chk({tag, "_busy"}, 64'(busy), 64'(e.busy));
    chk({tag, "_done"}, 64'(done), 64'(e.done));
  endtask

  // Expected per-cycle view of one run, cycle 1 = first after start.
  task automatic model(input int last, input int num,
                       input int sf, input int sl,
                       input int ab);
    int c;
    bit stop;
    c = 1;
    stop = 1'b0;
    if (num == 0) begin
      push(1'b0, 1'b1, IDLE_W);
      push(1'b0, 1'b0, IDLE_W);
      return;
    end
    for (int it = 0; it < num && !stop; it++) begin
      for (int p = 0; p <= last && !stop; p++) begin
        while (c >= sf && c < sf + sl) begin
          push(1'b1, 1'b0, IDLE_W);
          c++;
        end
        if (c == ab) begin
          stop = 1'b1;
        end else begin
          push(1'b1, 1'b0, ctx_m[p]);
          c++;
        end
      end
    end
    if (stop) begin
      push(1'b0, 1'b0, IDLE_W);
    end else begin
      push(1'b0, 1'b1, IDLE_W);
    end
    push(1'b0, 1'b0, IDLE_W);
  endtask

  task automatic run(input int last, input int num,
                     input int sf, input int sl,
                     input int ab, input bit junk,
                     input int maxc);
    int c;
    tnum++;
    model(last, num, sf, sl, ab);
    c = 1;
    while (q.size() > 0 && (maxc == 0 || c <= maxc)) begin
      start    = (c == 1);
      ctx_last = AW'(last);
      iter_num = IW'(num);
      stall    = (c >= sf && c < sf + sl);
      abort    = (c == ab);
      cfg_we   = junk;
      cfg_addr = '0;
      cfg_data = JUNK;
      tick();
      pop_check($sformatf("run%0d_c%0d", tnum, c));
      c++;
    end
    start  = 1'b0;
    stall  = 1'b0;
    abort  = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic cfg(input int a, input logic [46:0] w);
    cfg_we   = 1'b1;
    cfg_addr = AW'(a);
    cfg_data = w;
    tick();
    cfg_we   = 1'b0;
    ctx_m[a] = w;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    IDLE_W = pk(9'h0, 9'h0, 6'd63, 6'd63, 6'd0, 6'd0, 4'h0, 1'b0);
    JUNK   = pk(9'h1ff, 9'h1ff, 6'd1, 6'd2, 6'd3, 6'd4, 4'hf, 1'b1);
`ifdef PRED_CTRL_ERR_CHK_EN
    err_exp = 1'b1;
`else
    err_exp = 1'b0;
`endif

    tick();
    tick();
    chk("rst_word", 64'(obs_w), 64'(IDLE_W));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    RST_N = 1'b1;
    tick();

    cfg(0, pk(9'h008, 9'h0, 6'd5, 6'd0, 6'd0, 6'd0, 4'h0, 1'b0));
    cfg(1, pk(9'h001, 9'h008, 6'd7, 6'd0, 6'd0, 6'd5, 4'h0, 1'b0));
    cfg(2, pk(9'h002, 9'h0, 6'd9, 6'd3, 6'd3, 6'd0, 4'h4, 1'b1));
    cfg(3, pk(9'h010, 9'h002, 6'd11, 6'd12, 6'd1, 6'd2, 4'h8, 1'b1));

    run(1, 2, 0, 0, 0, 1'b0, 0);
    run(0, 0, 0, 0, 0, 1'b0, 0);
    run(3, 1, 2, 2, 0, 1'b1, 0);
    chk("err_after_busy_wr", 64'(err), 64'(0));

    run(3, 1, 0, 0, 3, 1'b0, 0);
    run(1, 1, 0, 0, 0, 1'b0, 0);

    run(3, 2, 0, 0, 0, 1'b0, 3);
    q.delete();
    RST_N = 1'b0;
    #1;
    chk("midrst_word", 64'(obs_w), 64'(IDLE_W));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    tick();
    RST_N = 1'b1;
    tick();
    run(1, 2, 0, 0, 0, 1'b0, 0);

    cfg(5, pk(9'h003, 9'h0, 6'd1, 6'd1, 6'd0, 6'd0, 4'h0, 1'b0));
    chk("err_set", 64'(err), 64'(err_exp));
    run(1, 1, 0, 0, 0, 1'b0, 0);
    chk("err_hold", 64'(err), 64'(err_exp));
    RST_N = 1'b0;
    #1;
    chk("err_rst", 64'(err), 64'(0));
    tick();
    RST_N = 1'b1;
    tick();
    run(3, 1, 0, 0, 0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
